// File: rtl/pwm_decode_if.sv
// Signal bundle between a half-bridge PWM monitor and the host that drives it.
// The host owns the gate-drive inputs and error clear; the monitor reports counts and faults.
interface pwm_decode_if;
    logic        en;
    logic        PWM1;
    logic        PWM2;
    logic        PWM_synch;
    logic        clr_err;
    logic [10:0] hi1_cnt;
    logic [10:0] hi2_cnt;
    logic        vld;
    logic        shoot_err;
    logic        dt_err;
    logic        per_err;
    logic        fault;

    modport master (
        output en, PWM1, PWM2, PWM_synch, clr_err,
        input  hi1_cnt, hi2_cnt, vld, shoot_err, dt_err, per_err, fault
    );

    modport slave (
        input  en, PWM1, PWM2, PWM_synch, clr_err,
        output hi1_cnt, hi2_cnt, vld, shoot_err, dt_err, per_err, fault
    );
endinterface

// File: rtl/pwm_decode.sv
// Half-bridge PWM monitor: measures per-period high time of both gate drives and
// flags shoot-through, short dead time and PWM_synch period errors.
module pwm_decode #(
    parameter logic [10:0] NONOVR_MIN = 11'd60,
    parameter logic [11:0] PERIOD     = 12'd2048
) (
    input  logic        clk,
    input  logic        rst,
    pwm_decode_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t      state;
    logic [10:0] acc1;
    logic [10:0] acc2;
    logic [10:0] gap_cnt;
    logic [11:0] per_cnt;
    logic [10:0] hi1_cnt_p1;
    logic [10:0] hi2_cnt_p1;
    logic        vld_p1;
    logic        fault_p1;
    logic        shoot_err_p1;
    logic        dt_err_p1;
    logic        per_err_p1;
    logic        pwm1_p1;
    logic        pwm2_p1;
    logic        ovl_p1;
    logic        edge_ok;
    logic        gap_armed;
    logic        last_fell2;

    logic        active;
    logic        in_meas;
    logic        rise1;
    logic        rise2;
    logic        fall1;
    logic        fall2;
    logic        both_low;
    logic        ovl;
    logic        shoot_new;
    logic        gap_short;
    logic        dt_viol;
    logic        synch_meas;
    logic        early;
    logic        late;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [10:0] acc_step(input logic [10:0] v, input logic hi);
        return hi ? sat_inc11(v) : v;
    endfunction

    always_comb begin
        active     = bus.en && (state != IDLE);
        in_meas    = active && (state == MEAS);
        // edge_ok masks the first cycle after IDLE, when the *_p1 copies are stale
        rise1      = active && edge_ok &&  bus.PWM1 && !pwm1_p1;
        rise2      = active && edge_ok &&  bus.PWM2 && !pwm2_p1;
        fall1      = active && edge_ok && !bus.PWM1 &&  pwm1_p1;
        fall2      = active && edge_ok && !bus.PWM2 &&  pwm2_p1;
        both_low   = !bus.PWM1 && !bus.PWM2;
        ovl        = active && bus.PWM1 && bus.PWM2;
        shoot_new  = ovl && !ovl_p1;
        gap_short  = gap_armed && (gap_cnt < NONOVR_MIN);
        dt_viol    = 1'b0;
        if (rise2 && ((fall1 && (NONOVR_MIN != 11'd0)) || (gap_short && !last_fell2)))
            dt_viol = 1'b1;
        if (rise1 && ((fall2 && (NONOVR_MIN != 11'd0)) || (gap_short && last_fell2)))
            dt_viol = 1'b1;
        synch_meas = in_meas && bus.PWM_synch;
        early      = synch_meas && (per_cnt != PERIOD - 12'd1);
        late       = in_meas && !bus.PWM_synch && (per_cnt == PERIOD - 12'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc1         <= '0;
            acc2         <= '0;
            gap_cnt      <= '0;
            per_cnt      <= '0;
            hi1_cnt_p1   <= '0;
            hi2_cnt_p1   <= '0;
            vld_p1       <= 1'b0;
            fault_p1     <= 1'b0;
            shoot_err_p1 <= 1'b0;
            dt_err_p1    <= 1'b0;
            per_err_p1   <= 1'b0;
            pwm1_p1      <= 1'b0;
            pwm2_p1      <= 1'b0;
            ovl_p1       <= 1'b0;
            edge_ok      <= 1'b0;
            gap_armed    <= 1'b0;
            last_fell2   <= 1'b0;
        end else begin
            vld_p1       <= 1'b0;
            fault_p1     <= shoot_new || dt_viol;
            // a new error in the clear cycle keeps its flag set
            shoot_err_p1 <= ovl || (shoot_err_p1 && !bus.clr_err);
            dt_err_p1    <= dt_viol || (dt_err_p1 && !bus.clr_err);
            per_err_p1   <= early || late || (per_err_p1 && !bus.clr_err);

            if (!bus.en) begin
                state      <= IDLE;
                acc1       <= '0;
                acc2       <= '0;
                per_cnt    <= '0;
                gap_cnt    <= '0;
                gap_armed  <= 1'b0;
                last_fell2 <= 1'b0;
                pwm1_p1    <= 1'b0;
                pwm2_p1    <= 1'b0;
                ovl_p1     <= 1'b0;
                edge_ok    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= ARM;
                        edge_ok <= 1'b0;
                    end
                    ARM: begin
                        // first partial period is discarded: no publish, no period check
                        if (bus.PWM_synch) begin
                            state   <= MEAS;
                            acc1    <= {10'd0, bus.PWM1};
                            acc2    <= {10'd0, bus.PWM2};
                            per_cnt <= '0;
                        end
                    end
                    MEAS: begin
                        if (bus.PWM_synch) begin
                            hi1_cnt_p1 <= acc1;
                            hi2_cnt_p1 <= acc2;
                            vld_p1     <= 1'b1;
                            acc1       <= {10'd0, bus.PWM1};
                            acc2       <= {10'd0, bus.PWM2};
                            per_cnt    <= '0;
                        end else begin
                            acc1    <= acc_step(acc1, bus.PWM1);
                            acc2    <= acc_step(acc2, bus.PWM2);
                            per_cnt <= sat_inc12(per_cnt);
                        end
                    end
                    default: state <= IDLE;
                endcase

                if (state != IDLE) begin
                    pwm1_p1 <= bus.PWM1;
                    pwm2_p1 <= bus.PWM2;
                    ovl_p1  <= ovl;
                    edge_ok <= 1'b1;
                    // gap counts both-low cycles, the falling cycle itself being the first
                    if (fall1 || fall2) begin
                        gap_cnt    <= both_low ? 11'd1 : 11'd0;
                        gap_armed  <= 1'b1;
                        last_fell2 <= fall2;
                    end else if (rise1 || rise2) begin
                        gap_cnt   <= '0;
                        gap_armed <= 1'b0;
                    end else if (both_low) begin
                        gap_cnt <= sat_inc11(gap_cnt);
                    end
                end
            end
        end
    end

    assign bus.hi1_cnt   = hi1_cnt_p1;
    assign bus.hi2_cnt   = hi2_cnt_p1;
    assign bus.vld       = vld_p1;
    assign bus.fault     = fault_p1;
    assign bus.shoot_err = shoot_err_p1;
    assign bus.dt_err    = dt_err_p1;
    assign bus.per_err   = per_err_p1;
endmodule

// File: tb/tb_pwm_decode.sv
// Directed bench for pwm_decode: period measurement, dead time, shoot-through,
// period errors, saturation, enable drop and mid-period reset.
module tb_pwm_decode;
    logic clk = 1'b0;
    logic rst;

    pwm_decode_if bus ();

    pwm_decode #(
        .NONOVR_MIN(11'd60),
        .PERIOD    (12'd2048)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   passes = 0;
    int   fails  = 0;
    int   total  = 0;
    int   vld_cnt;
    int   vld_idx;
    int   fault_cnt;
    logic pe0;
    logic snap_per;
    logic snap_sh;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One PWM period of len cycles: PWM1 high [0,h1), PWM2 high [s2,s2+h2),
    // optional synch at cycle 0, clr_err at cycle clr_at, snapshot at snap_at.
    task automatic run_period(input int len, input int h1, input int s2, input int h2,
                              input bit sy, input int clr_at, input int snap_at);
        vld_cnt   = 0;
        vld_idx   = -1;
        fault_cnt = 0;
        for (int i = 0; i < len; i++) begin
            bus.PWM_synch = sy && (i == 0);
            bus.PWM1      = (i < h1);
            bus.PWM2      = (i >= s2) && (i < s2 + h2);
            bus.clr_err   = (i == clr_at);
            tick();
            if (bus.vld) begin
                vld_cnt++;
                if (vld_idx < 0) vld_idx = i;
            end
            if (bus.fault) fault_cnt++;
            if (i == 0) pe0 = bus.per_err;
            if (i == snap_at) begin
                snap_per = bus.per_err;
                snap_sh  = bus.shoot_err;
            end
        end
        bus.PWM_synch = 1'b0;
        bus.clr_err   = 1'b0;
    endtask

    task automatic norm(input int clr_at);
        run_period(2048, 960, 1024, 959, 1'b1, clr_at, -1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.PWM1      = 1'b0;
        bus.PWM2      = 1'b0;
        bus.PWM_synch = 1'b0;
        bus.clr_err   = 1'b0;
        repeat (3) tick();
        chk("rst_hi1", bus.hi1_cnt, 0);
        chk("rst_hi2", bus.hi2_cnt, 0);
        chk("rst_vld", bus.vld, 0);
        chk("rst_shoot", bus.shoot_err, 0);
        chk("rst_dt", bus.dt_err, 0);
        chk("rst_per", bus.per_err, 0);
        chk("rst_fault", bus.fault, 0);

        // arm, then one clean measured period
        rst    = 1'b0;
        bus.en = 1'b1;
        tick();
        tick();
        norm(-1);
        chk("arm_no_vld", vld_cnt, 0);
        chk("arm_no_per", bus.per_err, 0);
        norm(-1);
        chk("p1_vld_cnt", vld_cnt, 1);
        chk("p1_vld_lat", vld_idx, 0);
        chk("p1_hi1", bus.hi1_cnt, 960);
        chk("p1_hi2", bus.hi2_cnt, 959);
        chk("p1_shoot", bus.shoot_err, 0);
        chk("p1_dt", bus.dt_err, 0);
        chk("p1_per", bus.per_err, 0);
        chk("p1_fault_cnt", fault_cnt, 0);

        // dead time of 40 clocks
        run_period(2048, 960, 1000, 959, 1'b1, -1, -1);
        chk("dt_err", bus.dt_err, 1);
        chk("dt_fault_cnt", fault_cnt, 1);
        chk("dt_no_shoot", bus.shoot_err, 0);
        norm(1500);
        chk("dt_pub_vld", vld_cnt, 1);
        chk("dt_pub_hi1", bus.hi1_cnt, 960);
        chk("dt_pub_hi2", bus.hi2_cnt, 959);
        chk("dt_cleared", bus.dt_err, 0);

        // three-cycle overlap, then clear colliding with a new overlap
        run_period(2048, 960, 957, 959, 1'b1, -1, -1);
        chk("sh_err", bus.shoot_err, 1);
        chk("sh_fault_cnt", fault_cnt, 1);
        chk("sh_no_dt", bus.dt_err, 0);
        run_period(2048, 960, 957, 959, 1'b1, 957, 957);
        chk("sh_set_wins", snap_sh, 1);
        chk("sh_fault_cnt2", fault_cnt, 1);
        norm(1500);
        chk("sh_cleared", bus.shoot_err, 0);
        chk("sh_pub_hi2", bus.hi2_cnt, 959);

        // early synch (2000) then late synch (2100)
        run_period(2000, 960, 1024, 959, 1'b1, -1, -1);
        chk("per_ontime", pe0, 0);
        run_period(2100, 960, 1024, 959, 1'b1, 10, 100);
        chk("per_early", pe0, 1);
        chk("per_clr", snap_per, 0);
        chk("per_late", bus.per_err, 1);
        chk("per_vld_cnt", vld_cnt, 1);
        chk("per_vld_lat", vld_idx, 0);
        norm(100);
        chk("per_pub_vld", vld_cnt, 1);
        chk("per_pub_hi1", bus.hi1_cnt, 960);
        chk("per_cleared", bus.per_err, 0);

        // PWM1 high for 3000 clocks saturates the accumulator
        run_period(3000, 3000, 0, 0, 1'b1, -1, -1);
        chk("sat_per", bus.per_err, 1);
        norm(100);
        chk("sat_hi1", bus.hi1_cnt, 11'h7FF);
        chk("sat_hi2", bus.hi2_cnt, 0);

        // en dropped mid-period: counts and sticky flags kept, no vld
        run_period(500, 500, 400, 50, 1'b1, -1, -1);
        bus.en   = 1'b0;
        bus.PWM1 = 1'b0;
        bus.PWM2 = 1'b0;
        vld_cnt  = 0;
        repeat (5) begin
            tick();
            if (bus.vld) vld_cnt++;
        end
        chk("en_low_no_vld", vld_cnt, 0);
        chk("en_low_hi1", bus.hi1_cnt, 960);
        chk("en_low_sticky", bus.shoot_err, 1);
        bus.en      = 1'b1;
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        tick();
        norm(-1);
        chk("rearm_no_vld", vld_cnt, 0);
        chk("rearm_no_per", bus.per_err, 0);
        chk("rearm_shoot_clr", bus.shoot_err, 0);
        norm(-1);
        chk("rearm_vld", vld_cnt, 1);

        // asynchronous reset mid-measurement (acc1 = 500)
        run_period(500, 500, 400, 50, 1'b1, -1, -1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hi1", bus.hi1_cnt, 0);
        chk("arst_hi2", bus.hi2_cnt, 0);
        chk("arst_shoot", bus.shoot_err, 0);
        chk("arst_vld", bus.vld, 0);
        chk("arst_fault", bus.fault, 0);
        bus.en   = 1'b0;
        bus.PWM1 = 1'b0;
        bus.PWM2 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        bus.en = 1'b1;
        tick();
        tick();
        norm(-1);
        chk("post_rst_no_vld", vld_cnt, 0);
        norm(-1);
        chk("post_rst_vld", vld_cnt, 1);
        chk("post_rst_hi1", bus.hi1_cnt, 960);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/pwm_decode.md
PWM_DECODE -- requirements
Module: pwm_decode

Interface
REQ-001 SHALL have parameter NONOVR_MIN, default 11'd60, minimum legal dead time in clocks between one PWM output falling and the other rising.
REQ-002 SHALL have parameter PERIOD, default 12'd2048, expected clocks between PWM_synch pulses.
REQ-003 clk  input  1  system clock; all state on rising edge; single clock domain.
REQ-004 rst  input  1  reset, asynchronous assert, active-high.
REQ-005 en  input  1  monitor enable; low holds the block in IDLE.
REQ-006 PWM1  input  1  high-side gate drive, same clock domain, no synchronizer.
REQ-007 PWM2  input  1  low-side gate drive, same clock domain.
REQ-008 PWM_synch  input  1  one-cycle pulse marking period start.
REQ-009 clr_err  input  1  synchronous clear of all sticky error flags.
REQ-010 hi1_cnt  output  11  clocks PWM1 was high in the last complete period.
REQ-011 hi2_cnt  output  11  clocks PWM2 was high in the last complete period.
REQ-012 vld  output  1  one-cycle pulse: hi1_cnt/hi2_cnt updated.
REQ-013 shoot_err  output  1  sticky: PWM1 and PWM2 both high in some cycle.
REQ-014 dt_err  output  1  sticky: dead-time gap shorter than NONOVR_MIN.
REQ-015 per_err  output  1  sticky: PWM_synch early, late or missing.
REQ-016 fault  output  1  registered, high for exactly one cycle after any new shoot-through or dead-time violation.

Function
REQ-017 FSM states: IDLE, ARM, MEAS.
- IDLE -> ARM when en=1.
- ARM -> MEAS on PWM_synch.
- Any state -> IDLE when en=0.
REQ-018 In MEAS, 11-bit accumulators acc1/acc2 SHALL increment in each cycle PWM1/PWM2 is high; saturate at 11'h7FF.
REQ-019 On PWM_synch in MEAS, SHALL copy acc1/acc2 to hi1_cnt/hi2_cnt and pulse vld in the next cycle (latency 1); accumulators restart, counting the synch cycle itself as cycle 0 of the new period.
REQ-020 Period counter SHALL reset to 0 on PWM_synch and increment each cycle in MEAS.
- PWM_synch with counter != PERIOD-1: set per_err and still publish.
- Counter reaching PERIOD-1 with no synch on the next cycle: set per_err, keep counting; publish at next synch.
REQ-021 ARM -> MEAS transition SHALL NOT publish or raise per_err (first partial period discarded).
REQ-022 shoot_err SHALL set in any cycle (IDLE excluded) with PWM1 & PWM2 = 1; checked in ARM and MEAS.
REQ-023 Gap counter (11 bits, saturating) SHALL clear on a falling edge of either PWM and count while both are low.
- Rising edge of the opposite output with gap < NONOVR_MIN sets dt_err.
- Rising edge of the same output that fell resets the gap without a check.
REQ-024 Edge detection SHALL use one registered copy of PWM1/PWM2; first cycle after leaving IDLE SHALL NOT report edges.
REQ-025 clr_err SHALL clear sticky flags; if an error condition occurs in the same cycle, the flag SHALL be set (set wins).
REQ-026 en falling mid-period: accumulators, period and gap counters cleared; hi1_cnt/hi2_cnt and sticky flags retained; no vld.

Reset
REQ-027 On rst: state IDLE; hi1_cnt, hi2_cnt, all counters = 0; vld, fault, shoot_err, dt_err, per_err = 0; edge registers = 0.
REQ-028 Reset asserted mid-period SHALL abort measurement with no vld; after release, ARM is re-entered only via en.

Verification
REQ-029 en=1, synch every 2048 clocks, PWM1 high 960 clocks, 64 low, PWM2 high 959 -> vld one cycle after second synch, hi1_cnt=960, hi2_cnt=959, no errors.
REQ-030 PWM2 rises 40 clocks after PWM1 falls, NONOVR_MIN=60 -> dt_err=1 and fault pulse 1 cycle; hi counts still published.
REQ-031 PWM1 and PWM2 both high for 3 cycles -> shoot_err=1, single fault pulse; clr_err same cycle as a new overlap -> shoot_err stays 1.
REQ-032 Synch at 2000 clocks, then none for 2100 -> per_err=1 on both; vld only at actual synch pulses.
REQ-033 PWM1 held high 3000 clocks (synch suppressed) -> hi1_cnt=11'h7FF after next synch, per_err=1.
REQ-034 rst mid-MEAS with acc1=500 -> all outputs 0; no vld until en, synch and a full period have elapsed.
